xadc_channel_reader: RTL and testbench
======================================

# xadc_channel_reader

Upstream feeder for the boost converter controller. Services the XADC end-of-conversion strobe and reads each converted result over the DRP port. Routes the inductor-current, input-voltage and output-voltage channels into held registers (`il_adc`, `vin_adc`, `vout_adc`). Qualifies them with `xadc_valid`, which the controller uses to gate switching. Also keeps DRP timeout and EOC overrun counters.

## Interface
- `IL_CHANNEL`, default 5'd19 — XADC channel number of the inductor current sense.
- `VIN_CHANNEL`, default 5'd20 — channel number of the input-voltage divider.
- `VOUT_CHANNEL`, default 5'd21 — channel number of the output-voltage divider.
- `DRP_TIMEOUT`, default 64 — cycles to wait for `drdy_i` after `den_o`.
- `STALE_LIMIT`, default 100000 — cycles without refresh after which a channel is stale.
- `clk`  in  1  — system clock; the only clock.
- `reset`  in  1  — synchronous, active-high reset.
- `eoc_i`  in  1  — XADC end-of-conversion pulse.
- `channel_i`  in  5  — XADC channel number, valid with `eoc_i`.
- `daddr_o`  out  7  — DRP address.
- `den_o`  out  1  — DRP enable, one-cycle pulse.
- `dwe_o`  out  1  — DRP write enable, tied to 0.
- `di_o`  out  16  — DRP write data, tied to 0.
- `do_i`  in  16  — DRP read data.
- `drdy_i`  in  1  — DRP data ready.
- `il_adc`  out  10  — inductor current, `do_i[15:6]`.
- `vin_adc`  out  12  — input voltage, `do_i[15:4]`.
- `vout_adc`  out  12  — output voltage, `do_i[15:4]`.
- `xadc_valid`  out  1  — all three channels fresh.
- `timeout_count`  out  8  — saturating count of DRP timeouts.
- `overrun_count`  out  8  — saturating count of dropped EOCs.

## Operation
**Reset values:** every output, counter, flag and the FSM (IDLE) are 0 / IDLE.

**FSM states:** IDLE, REQ, WAIT.
- **IDLE**
  - If `eoc_i` is high, latch `channel_i` into `cur_ch` and go to REQ.
  - Else, if `pend_valid`, load `cur_ch` from `pend_ch`, clear `pend_valid`, and go to REQ.
- **REQ**
  - `den_o`=1 for exactly this cycle, with `daddr_o`={2'b00,`cur_ch`}.
  - Clear `wait_cnt` and go to WAIT.
- **WAIT**
  - If `drdy_i` is high: capture `do_i` into the matching output register and clear that channel's stale counter. A non-matching channel is discarded with no error. Go to IDLE.
  - Else, if `wait_cnt` == `DRP_TIMEOUT`-1: increment `timeout_count` (saturating at 255), leave no register updated, and go to IDLE.
  - Otherwise, `wait_cnt` increments.

**EOC arriving outside IDLE:**
- If `pend_valid`=0, store it in `pend_ch` and set `pend_valid`.
- If `pend_valid`=1, overwrite `pend_ch` with the newest channel and increment `overrun_count` (saturating).

**Staleness:**
- Three 17-bit stale counters increment every cycle, saturating at `STALE_LIMIT`.
- A `seen_x` bit is set on a channel's first capture.

**Validity:**
- `xadc_valid` is registered: `seen_il`&`seen_vin`&`seen_vout` and all stale counters < `STALE_LIMIT`.
- It drops one cycle after any counter reaches the limit.
- A DRP timeout does not directly clear `xadc_valid`.

**Data latches:** `daddr_o` and the data outputs hold their last value between updates.

## Timing
- `eoc_i` sampled high in IDLE at edge N → `den_o` high in cycle N+1 (registered output).
- `drdy_i` sampled high at edge R → data output visible from R+1; `xadc_valid` may rise at R+2.
- Minimum EOC-to-data latency is 3 cycles (eoc → REQ → WAIT with `drdy_i` on the first WAIT cycle).
- Minimum back-to-back service interval is 3 cycles per conversion.
- `drdy_i` while in IDLE or REQ is ignored.
- `drdy_i` and timeout in the same cycle: data wins; no timeout is counted.
- `eoc_i` and `drdy_i` in the same WAIT cycle: the data is stored and the EOC goes to the pending slot.
- `reset` asserted mid-transaction: FSM returns to IDLE next edge, and all outputs and counters clear. A late `drdy_i` afterwards is ignored.

## Structure
- Shared package `boost_pkg` holds:
  - the FSM state encoding (IDLE=0, REQ=1, WAIT=2);
  - default channel numbers;
  - ADC field-slice constants (`IL_MSB/LSB`=15/6, `V_MSB/LSB`=15/4).
- No sub-module. The three stale counters are a generate loop inside the block.

## Test plan
- **Initial valid:** after reset, EOCs on 19, 20, 21 with `do_i`=16'hABC0, 16'h1230, 16'hFFF0 → `il_adc`=10'h2AF, `vin_adc`=12'h123, `vout_adc`=12'hFFF. `xadc_valid` rises 2 cycles after the third `drdy_i`.
- **DRP timeout:** `drdy_i` never returned → `den_o` a single pulse, `timeout_count`=1 after 64 WAIT cycles, outputs unchanged, FSM back in IDLE.
- **Overrun:** three EOCs (20, 21, 19) during one WAIT → `overrun_count`=1 and the pending read targets channel 19.
- **Staleness:** with `STALE_LIMIT`=100 and `vout` not refreshed for 100 cycles → `xadc_valid` falls. The next `vout` capture restores it 2 cycles after `drdy_i`.
- **Reset mid-transaction:** reset during WAIT, then a stray `drdy_i` → all outputs stay 0 and `seen` bits stay clear.
- **Unmapped channel:** EOC on channel 3 → DRP read to address 7'h03 is issued, no output changes, no counters change.

Source files
------------

// File: rtl/boost_pkg.sv
// -----------------------------------------------------------------------------
// boost_pkg
// Shared definitions for the boost converter front end. Holds the XADC reader
// FSM encoding, default XADC channel numbers, the ADC field slices and a
// saturating counter helper.
// No ports (package).
// -----------------------------------------------------------------------------
package boost_pkg;

  // Reader FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } reader_state_e;

  // Default XADC channel assignment on the board
  localparam logic [4:0] DEF_IL_CHANNEL   = 5'd19;
  localparam logic [4:0] DEF_VIN_CHANNEL  = 5'd20;
  localparam logic [4:0] DEF_VOUT_CHANNEL = 5'd21;

  // Result slices within the 16-bit DRP word (conversion is MSB-aligned)
  localparam int IL_MSB = 15;
  localparam int IL_LSB = 6;
  localparam int V_MSB  = 15;
  localparam int V_LSB  = 4;

  // Channel slot indices used for the stale/seen bookkeeping
  localparam int NUM_CH  = 3;
  localparam int CH_IL   = 0;
  localparam int CH_VIN  = 1;
  localparam int CH_VOUT = 2;

  // Increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/xadc_channel_reader.sv
// -----------------------------------------------------------------------------
// xadc_channel_reader
// Services XADC end-of-conversion strobes, reads each result over DRP and
// routes the inductor-current / input-voltage / output-voltage channels into
// held registers. xadc_valid qualifies the three values as all seen and fresh.
//
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   eoc_i, channel_i      - XADC end-of-conversion pulse and its channel
//   daddr_o, den_o        - DRP read address and one-cycle enable
//   dwe_o, di_o           - DRP write controls, held at 0 (read only)
//   do_i, drdy_i          - DRP read data and data-ready
//   il_adc, vin_adc,
//   vout_adc              - held converted values
//   xadc_valid            - all three channels captured and none stale
//   timeout_count         - saturating count of DRP reads that never returned
//   overrun_count         - saturating count of EOCs lost from the pending slot
// -----------------------------------------------------------------------------
module xadc_channel_reader
  import boost_pkg::*;
#(
  parameter logic [4:0] IL_CHANNEL   = DEF_IL_CHANNEL,
  parameter logic [4:0] VIN_CHANNEL  = DEF_VIN_CHANNEL,
  parameter logic [4:0] VOUT_CHANNEL = DEF_VOUT_CHANNEL,
  parameter int         DRP_TIMEOUT  = 64,
  parameter int         STALE_LIMIT  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eoc_i,
  input  logic [4:0]  channel_i,
  output logic [6:0]  daddr_o,
  output logic        den_o,
  output logic        dwe_o,
  output logic [15:0] di_o,
  input  logic [15:0] do_i,
  input  logic        drdy_i,
  output logic [9:0]  il_adc,
  output logic [11:0] vin_adc,
  output logic [11:0] vout_adc,
  output logic        xadc_valid,
  output logic [7:0]  timeout_count,
  output logic [7:0]  overrun_count
);

  localparam int WCW = (DRP_TIMEOUT > 1) ? $clog2(DRP_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(DRP_TIMEOUT - 1);
  localparam logic [16:0]    STALE_MAX = 17'(STALE_LIMIT);

  // Slot order matches CH_IL / CH_VIN / CH_VOUT
  localparam logic [NUM_CH-1:0][4:0] CH_MAP = {VOUT_CHANNEL, VIN_CHANNEL, IL_CHANNEL};

  reader_state_e   state_q;
  logic [4:0]      cur_ch_q;
  logic [4:0]      pend_ch_q;
  logic            pend_valid_q;
  logic [WCW-1:0]  wait_cnt_q;
  logic            den_q;
  logic [6:0]      daddr_q;
  logic [9:0]      il_q;
  logic [11:0]     vin_q;
  logic [11:0]     vout_q;
  logic            valid_q;
  logic [7:0]      timeout_q;
  logic [7:0]      overrun_q;

  logic              rd_done;
  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] seen;
  logic [NUM_CH-1:0] fresh;

  // The low nibble of the DRP word is below the used resolution
  logic do_low_unused;
  assign do_low_unused = ^do_i[3:0];

  // drdy_i only counts while a read is outstanding
  assign rd_done = (state_q == WAIT) && drdy_i;

  // Per-channel capture strobe, stale counter and first-capture flag
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [16:0] stale_q;
      logic [16:0] stale_d;
      logic        seen_q;

      assign cap[gi] = rd_done && (cur_ch_q == CH_MAP[gi]);

      always_comb begin
        stale_d = stale_q;
        if (cap[gi]) begin
          stale_d = '0;
        end else if (stale_q != STALE_MAX) begin
          stale_d = stale_q + 17'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          stale_q <= '0;
          seen_q  <= 1'b0;
        end else begin
          stale_q <= stale_d;
          if (cap[gi]) begin
            seen_q <= 1'b1;
          end
        end
      end

      assign seen[gi]  = seen_q;
      assign fresh[gi] = (stale_q < STALE_MAX);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_ch_q     <= '0;
      pend_ch_q    <= '0;
      pend_valid_q <= 1'b0;
      wait_cnt_q   <= '0;
      den_q        <= 1'b0;
      daddr_q      <= '0;
      il_q         <= '0;
      vin_q        <= '0;
      vout_q       <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= '0;
      overrun_q    <= '0;
    end else begin
      den_q   <= 1'b0;
      valid_q <= (&seen) && (&fresh);

      // An EOC that cannot be serviced now parks in a one-deep slot; a second
      // one replaces it so the newest conversion is the one read.
      if (eoc_i && (state_q != IDLE)) begin
        pend_ch_q    <= channel_i;
        pend_valid_q <= 1'b1;
        if (pend_valid_q) begin
          overrun_q <= sat_inc8(overrun_q);
        end
      end

      case (state_q)
        IDLE: begin
          if (eoc_i) begin
            cur_ch_q <= channel_i;
            daddr_q  <= {2'b00, channel_i};
            den_q    <= 1'b1;
            state_q  <= REQ;
          end else if (pend_valid_q) begin
            cur_ch_q     <= pend_ch_q;
            daddr_q      <= {2'b00, pend_ch_q};
            pend_valid_q <= 1'b0;
            den_q        <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // Data takes priority over a timeout landing on the same cycle
          if (drdy_i) begin
            if (cap[CH_IL])   il_q   <= do_i[IL_MSB:IL_LSB];
            if (cap[CH_VIN])  vin_q  <= do_i[V_MSB:V_LSB];
            if (cap[CH_VOUT]) vout_q <= do_i[V_MSB:V_LSB];
            state_q <= IDLE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            timeout_q <= sat_inc8(timeout_q);
            state_q   <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign daddr_o       = daddr_q;
  assign den_o         = den_q;
  assign dwe_o         = 1'b0;
  assign di_o          = '0;
  assign il_adc        = il_q;
  assign vin_adc       = vin_q;
  assign vout_adc      = vout_q;
  assign xadc_valid    = valid_q;
  assign timeout_count = timeout_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_xadc_channel_reader.sv
// -----------------------------------------------------------------------------
// tb_xadc_channel_reader
// Directed self-checking bench for xadc_channel_reader (STALE_LIMIT = 100).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_xadc_channel_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        eoc_i;
  logic [4:0]  channel_i;
  logic [6:0]  daddr_o;
  logic        den_o;
  logic        dwe_o;
  logic [15:0] di_o;
  logic [15:0] do_i;
  logic        drdy_i;
  logic [9:0]  il_adc;
  logic [11:0] vin_adc;
  logic [11:0] vout_adc;
  logic        xadc_valid;
  logic [7:0]  timeout_count;
  logic [7:0]  overrun_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int den_cnt  = 0;
  int cv;
  int d0;

  xadc_channel_reader #(
    .STALE_LIMIT(100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .eoc_i        (eoc_i),
    .channel_i    (channel_i),
    .daddr_o      (daddr_o),
    .den_o        (den_o),
    .dwe_o        (dwe_o),
    .di_o         (di_o),
    .do_i         (do_i),
    .drdy_i       (drdy_i),
    .il_adc       (il_adc),
    .vin_adc      (vin_adc),
    .vout_adc     (vout_adc),
    .xadc_valid   (xadc_valid),
    .timeout_count(timeout_count),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (den_o) den_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full read from IDLE: EOC, REQ, `delay` silent WAIT cycles, then drdy
  task automatic drp_read(input logic [4:0] ch, input logic [15:0] data, input int delay);
    eoc_i = 1'b1; channel_i = ch;
    step();
    eoc_i = 1'b0;
    step();
    repeat (delay) step();
    drdy_i = 1'b1; do_i = data;
    step();
    drdy_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; eoc_i = 1'b0; channel_i = '0; do_i = '0; drdy_i = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_il",      il_adc,        0);
    chk("rst_vin",     vin_adc,       0);
    chk("rst_vout",    vout_adc,      0);
    chk("rst_valid",   xadc_valid,    0);
    chk("rst_timeout", timeout_count, 0);
    chk("rst_overrun", overrun_count, 0);
    chk("rst_den",     den_o,         0);
    chk("rst_daddr",   daddr_o,       0);
    chk("rst_dwe",     dwe_o,         0);
    chk("rst_di",      di_o,          0);

    // Initial valid
    drp_read(5'd19, 16'hABC0, 0);
    chk("init_il", il_adc, 10'h2AF);
    chk("init_valid_early", xadc_valid, 0);
    drp_read(5'd20, 16'h1230, 0);
    chk("init_vin", vin_adc, 12'h123);
    drp_read(5'd21, 16'hFFF0, 0);
    chk("init_vout", vout_adc, 12'hFFF);
    chk("init_valid_r1", xadc_valid, 0);
    step();
    chk("init_valid_r2", xadc_valid, 1);
    chk("init_daddr", daddr_o, 7'h15);

    // Unmapped channel
    d0 = den_cnt;
    drp_read(5'd3, 16'h5555, 1);
    chk("unmap_daddr",   daddr_o, 7'h03);
    chk("unmap_den",     den_cnt - d0, 1);
    chk("unmap_il",      il_adc, 10'h2AF);
    chk("unmap_vin",     vin_adc, 12'h123);
    chk("unmap_vout",    vout_adc, 12'hFFF);
    chk("unmap_timeout", timeout_count, 0);
    chk("unmap_overrun", overrun_count, 0);

    // Overrun: EOC 20 starts a read, 21 and 19 arrive during WAIT
    eoc_i = 1'b1; channel_i = 5'd20;
    step();
    eoc_i = 1'b0;
    step();
    eoc_i = 1'b1; channel_i = 5'd21;
    step();
    channel_i = 5'd19;
    step();
    eoc_i = 1'b0; drdy_i = 1'b1; do_i = 16'h4560;
    step();
    drdy_i = 1'b0;
    chk("ovr_count", overrun_count, 1);
    chk("ovr_vin", vin_adc, 12'h456);
    step();
    chk("ovr_pend_den", den_o, 1);
    chk("ovr_pend_daddr", daddr_o, 7'h13);
    step();
    drdy_i = 1'b1; do_i = 16'h4000;
    step();
    drdy_i = 1'b0;
    chk("ovr_pend_il", il_adc, 10'h100);
    chk("ovr_count_hold", overrun_count, 1);

    // Staleness: refresh il/vin only, let vout age to the limit
    drp_read(5'd21, 16'h7770, 0);
    cv = cyc;
    chk("stale_vout", vout_adc, 12'h777);
    while (cyc < cv + 90) begin
      drp_read(5'd19, 16'h1000, 0);
      drp_read(5'd20, 16'h2000, 0);
    end
    while (cyc < cv + 100) step();
    chk("stale_valid_before", xadc_valid, 1);
    step();
    chk("stale_valid_drop", xadc_valid, 0);
    drp_read(5'd21, 16'h8000, 0);
    chk("stale_vout_new", vout_adc, 12'h800);
    chk("stale_valid_r1", xadc_valid, 0);
    step();
    chk("stale_valid_r2", xadc_valid, 1);

    // DRP timeout
    d0 = den_cnt;
    eoc_i = 1'b1; channel_i = 5'd20;
    step();
    eoc_i = 1'b0;
    repeat (64) step();
    chk("tmo_not_yet", timeout_count, 0);
    step();
    chk("tmo_count", timeout_count, 1);
    chk("tmo_den_pulses", den_cnt - d0, 1);
    chk("tmo_vin_hold", vin_adc, 12'h200);
    drp_read(5'd20, 16'h3330, 0);
    chk("tmo_back_idle", vin_adc, 12'h333);

    // drdy on the last WAIT cycle: data wins over timeout
    drp_read(5'd19, 16'hFFC0, 63);
    chk("tmo_edge_il", il_adc, 10'h3FF);
    chk("tmo_edge_count", timeout_count, 1);

    // Reset mid-transaction, then a stray drdy
    eoc_i = 1'b1; channel_i = 5'd21;
    step();
    eoc_i = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drdy_i = 1'b1; do_i = 16'hAAAA;
    step();
    drdy_i = 1'b0;
    chk("mid_il",      il_adc,        0);
    chk("mid_vin",     vin_adc,       0);
    chk("mid_vout",    vout_adc,      0);
    chk("mid_valid",   xadc_valid,    0);
    chk("mid_timeout", timeout_count, 0);
    chk("mid_overrun", overrun_count, 0);
    chk("mid_daddr",   daddr_o,       0);
    chk("mid_den",     den_o,         0);
    drp_read(5'd19, 16'h0400, 0);
    drp_read(5'd20, 16'h0400, 0);
    step();
    step();
    chk("mid_il_after", il_adc, 10'h010);
    chk("mid_seen_clear", xadc_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
